u_rca24_arb: RTL

Shared-adder arbiter that time-multiplexes one 24-bit unsigned ripple-carry adder instance (`f_u_rca24`) among `NREQ` requesters. Each requester uses a valid/ready handshake. The arbiter grants at most one request per cycle and registers the 25-bit sum together with the winner's index into a one-entry output stage with backpressure. It sits between several datapath clients and the single flat adder, so the adder's area is paid once.

---
 rtl/u_rca24_arb.sv | 111 +++++++++++
 1 files changed

// File: rtl/u_rca24_arb.sv
// Shared 24-bit ripple-carry adder arbitrated among NREQ requesters.
// Define U_RCA24_ARB_RR_EN for round-robin; default is fixed priority.
module f_u_rca24 (
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic [24:0] s
);
  logic [24:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < 24; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) |
                    (c[i] & (a[i] ^ b[i]));
  end

  assign s[24] = c[24];
endmodule

module u_rca24_arb #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*24-1:0] req_a,
  input  logic [NREQ*24-1:0] req_b,
  output logic [NREQ-1:0]    req_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [24:0]        out_sum,
  output logic [IDW-1:0]     out_id
);
  logic           stage_free;
  logic           found;
  logic           accept;
  logic [IDW-1:0] win;
  logic [23:0]    a_arr [NREQ];
  logic [23:0]    b_arr [NREQ];
  logic [24:0]    sum;

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign a_arr[i] = req_a[24*i +: 24];
    assign b_arr[i] = req_b[24*i +: 24];
  end

  assign stage_free = !out_valid || out_ready;

`ifdef U_RCA24_ARB_RR_EN
  logic [IDW-1:0] ptr;
  logic [IDW:0]   idx;

  // Scan from the pointer upward, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ))
        idx = idx - (IDW+1)'(NREQ);
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end
`else
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[k]) begin
        found = 1'b1;
        win   = IDW'(k);
      end
    end
  end
`endif

  assign accept    = found && stage_free && !rst;
  assign req_ready = accept ? (NREQ'(1) << win) : '0;

  f_u_rca24 u_add (
    .a(a_arr[win]),
    .b(b_arr[win]),
    .s(sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_id    <= '0;
`ifdef U_RCA24_ARB_RR_EN
      ptr       <= '0;
`endif
    end else if (accept) begin
      out_valid <= 1'b1;
      out_sum   <= sum;
      out_id    <= win;
`ifdef U_RCA24_ARB_RR_EN
      ptr <= (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
